// File: rtl/dmem_pkg.sv
// Shared types, constants and helpers for the KGP-RISC data memory controller.
// be_merge works at a fixed maximum width; callers zero-extend and truncate.
package dmem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } dmem_state_e;

    localparam int RD_LAT_MAX = 4;
    localparam int MERGE_W    = 128;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/dmem_rsp_pipe.sv
// Fixed-latency response delay line carrying {valid, err, rdata}.
// Flushed synchronously on reset; outputs are forced idle while reset is high.
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_rdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata
);
    // Out-of-range latencies are clamped into the supported 1..RD_LAT_MAX window.
    localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    logic [LAT-1:0]             valid_q;
    logic [LAT-1:0]             err_q;
    logic [LAT-1:0][DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            rdata_q[0] <= in_rdata;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign rsp_valid = valid_q[LAT-1] & ~reset;
    assign rsp_err   = err_q[LAT-1] & valid_q[LAT-1] & ~reset;
    assign rsp_rdata = (valid_q[LAT-1] && !reset) ? rdata_q[LAT-1] : '0;

endmodule

// File: rtl/dmem_ctrl.sv
// Word-addressed data memory with byte strobes, range checking, registered
// fixed-latency responses and a sequential clear after every reset.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_e       state_q, state_d;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;
    logic              cnt_last;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    // Compare one bit wider so DEPTH == 2**ADDR_W does not truncate to zero.
    assign in_range = {1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH);
    assign idx      = bus.req_addr[IDX_W-1:0];
    assign cnt_last = (cnt_q == IDX_W'(DEPTH-1));
    assign accept   = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs are also gated by reset so a mid-run reset blocks accepts at once.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.init_done = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.req_ready = ~reset;
                bus.init_done = ~reset;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT && !cnt_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // DATA_W is limited to MERGE_W bits by the shared byte-merge helper.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= '0;
        end else if (accept && bus.req_we && in_range) begin
            mem[idx] <= DATA_W'(be_merge(MERGE_W'(mem[idx]),
                                         MERGE_W'(bus.req_wdata),
                                         MERGE_BE_W'(bus.req_be)));
        end
    end

    assign rd_word = (accept && !bus.req_we && in_range) ? mem[idx] : '0;

    dmem_rsp_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_err    (accept & ~in_range),
        .in_rdata  (rd_word),
        .rsp_valid (bus.rsp_valid),
        .rsp_err   (bus.rsp_err),
        .rsp_rdata (bus.rsp_rdata)
    );

endmodule
